user_proj_uart_tx: RTL and testbench
====================================

# user_proj_uart_tx

Wishbone-slave UART transmitter that sits inside the user project wrapper, directly downstream of the management-SoC Wishbone port. It drives one user GPIO pad. Software writes bytes into an internal FIFO. A baud-rate engine serialises them onto the pad as 8N1 frames (8E1 when parity is compiled in). An interrupt is raised when the FIFO drains.

## Interface
Parameters:
- FIFO_DEPTH, 8: TX FIFO entries; power of two, 2..64.
- TX_PIN, 6: index of the io pad driven by the serial output.
- DIV_RESET, 16'd434: reset value of the baud divisor register.

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; only sel[0] and sel[1] are honoured.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- io_out  out  `MPRJ_IO_PADS  pad outputs; only TX_PIN is driven, all other bits are 0.
- io_oeb  out  `MPRJ_IO_PADS  active-low output enables; bit TX_PIN = !CTRL.en, all other bits are 1.
- irq  out  3  irq[0] = CTRL.en & CTRL.irq_en & fifo_empty & !busy; irq[2:1] = 0.

## Operation
- Select: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == 24'h300000). Register offset = wbs_adr_i[3:2].
- Registers:
  - 0x00 DATA: write pushes wbs_dat_i[7:0] into the FIFO when sel[0] is set. Reads return 0.
  - 0x04 STATUS (read):
    - bit0 busy (frame in progress).
    - bit1 full.
    - bit2 empty.
    - bit3 overflow (sticky).
    - [14:8] FIFO level.
    - Writing 1 to bit3 clears overflow; other bits are read-only.
  - 0x08 DIV: [15:0] bit period in clocks. A value of 0 behaves as 1.
  - 0x0C CTRL: bit0 en, bit1 irq_en. Reset value 0.
- Unselected offsets read 0. Writes to them are acked and ignored.
- Push while full: byte dropped, overflow set, FIFO unchanged.
- Transmit state machine, states IDLE, START, DATA, PARITY (macro only), STOP:
  - IDLE -> START when en & !empty. The head entry is popped in the same cycle.
  - START: line 0 for DIV cycles.
  - DATA: 8 bits, LSB first, each held DIV cycles.
  - STOP: line 1 for DIV cycles, then -> IDLE. Back-to-back: STOP -> START directly when en & !empty at the last stop cycle.
- busy = state != IDLE.
- Clearing en mid-frame: the current frame completes, then the machine stays in IDLE. io_oeb[TX_PIN] goes high immediately; io_out continues internally.
- Changing DIV mid-frame: the change takes effect at the next bit boundary.
- Simultaneous push and pop in one cycle: level unchanged and both operations complete. A push when full coincident with a pop is accepted.

## Timing
- Ack: registered. wbs_ack_o rises the cycle after select and holds for 1 cycle. It is not reasserted while ack is high, so a new cycle needs stb held or re-asserted after ack.
- Read data is valid in the ack cycle. wbs_dat_o is 0 when ack is low.
- Pushed data is visible in STATUS.level the cycle after ack.
- Pop-to-start latency: line falls 1 cycle after the IDLE -> START decision.
- Frame length: 10×DIV cycles (11×DIV with parity).
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0.
  - io_out all 0 except io_out[TX_PIN]=1 (idle high).
  - io_oeb all 1, irq=0.
  - FIFO empty, overflow 0, DIV=DIV_RESET, state IDLE.
- Reset mid-frame aborts the frame: line is 1 and the FIFO is empty after the reset edge.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is inserted between DATA and STOP, transmitting the even-parity bit (XOR of the 8 data bits) for DIV cycles. CTRL bit2 pe enables it; when pe=0 the frame is 8N1.
  - Undefined: no PARITY state, CTRL bit2 reads 0, and frames are always 8N1.

## Test plan
- Reset: hold wb_rst_i 2 cycles. Then io_out[TX_PIN]=1, io_oeb=all 1s, STATUS=0x00000004, DIV reads 434.
- Single frame: DIV=4, CTRL=1, write 0x55. Line samples every 4 cycles read 0,1,0,1,0,1,0,1,0,1; busy is high for 40 cycles.
- Overflow: CTRL=0, write 9 bytes with FIFO_DEPTH=8. STATUS reads level=8, full=1, overflow=1. Writing 0x8 to STATUS clears overflow only.
- Back-to-back and IRQ: DIV=2, CTRL=3, write 0xA0 and 0x0F. Two frames run with no idle gap (40 cycles). irq[0] rises 1 cycle after the final stop bit ends.
- Disable mid-frame: clear en at bit 3 of a frame with 2 bytes queued. The current frame completes internally, the second byte stays queued (level=1), and io_oeb[TX_PIN]=1 from the cycle after the write ack.
- Parity (macro defined): CTRL=5, DIV=3, write 0x07. The parity bit is 1, and the frame is 33 cycles long.

Source files
------------

// File: rtl/user_proj_uart_tx.sv
// user_proj_uart_tx: Wishbone-slave UART transmitter for the user project wrapper.
// Software pushes bytes into a TX FIFO. A baud engine shifts each byte onto one io pad
// as an 8N1 frame, or 8E1 when parity is compiled in and enabled.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock; synchronous active-high reset
//   wbs_*                  Wishbone slave (page 0x3000_00xx, regs DATA/STATUS/DIV/CTRL)
//   io_out / io_oeb        pad outputs / active-low enables; only bit TX_PIN is used
//   irq[0]                 en & irq_en & FIFO empty & transmitter idle; irq[2:1] tied 0
//
// Optional feature macro: UART_TX_PARITY_EN (even-parity bit, enabled by CTRL.pe).

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module user_proj_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TX_PIN     = 6,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [`MPRJ_IO_PADS-1:0] io_out,
  output logic [`MPRJ_IO_PADS-1:0] io_oeb,
  output logic [2:0]               irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DepthLvl = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // Wishbone
  logic        w_sel, w_acc, w_wr, w_rd;
  logic [1:0]  w_off;
  logic        r_ack;
  logic [31:0] r_dat, w_rdata;
  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          w_full, w_empty, w_push_req, w_push, w_pop;
  logic [7:0]    w_head;
  logic          r_ovf;
  // Control
  logic [15:0] r_div, w_div_eff;
  logic        r_en, r_irq_en, w_pe;
  // Transmitter
  state_e      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_line, w_line_nxt;
  logic        w_bit_end, w_busy, w_start;
  logic        w_unused;

  assign w_unused = ^{wbs_adr_i[7:4], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  // Ack is withheld for one cycle after each ack so a held strobe yields one access per pair.
  assign w_sel = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == 24'h300000);
  assign w_acc = w_sel & ~r_ack;
  assign w_wr  = w_acc & wbs_we_i;
  assign w_rd  = w_acc & ~wbs_we_i;
  assign w_off = wbs_adr_i[3:2];

  always_comb begin
    w_rdata = '0;
    unique case (w_off)
      2'd1:    w_rdata = {17'd0, 7'(r_level), 4'd0, r_ovf, w_empty, w_full, w_busy};
      2'd2:    w_rdata[15:0] = r_div;
      2'd3:    w_rdata[2:0] = {w_pe, r_irq_en, r_en};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  // Control and status registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_div    <= DIV_RESET;
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_req && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_off == 2'd1) && wbs_sel_i[0] && wbs_dat_i[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_off == 2'd2)) begin
        if (wbs_sel_i[0]) r_div[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) r_div[15:8] <= wbs_dat_i[15:8];
      end
      if (w_wr && (w_off == 2'd3) && wbs_sel_i[0]) begin
        r_en     <= wbs_dat_i[0];
        r_irq_en <= wbs_dat_i[1];
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  logic r_pe, r_par;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_pe  <= 1'b0;
      r_par <= 1'b0;
    end else begin
      if (w_wr && (w_off == 2'd3) && wbs_sel_i[0]) r_pe <= wbs_dat_i[2];
      if (w_start) r_par <= ^w_head;
    end
  end
  assign w_pe = r_pe;
`else
  assign w_pe = 1'b0;
`endif

  // TX FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
  assign w_full     = (r_level == DepthLvl);
  assign w_empty    = (r_level == '0);
  assign w_push_req = w_wr & (w_off == 2'd0) & wbs_sel_i[0];
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_head     = r_mem[r_rptr];

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= wbs_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Transmitter. r_cnt counts down the cycles left in the current bit; the bit period is
  // sampled from DIV at each bit boundary so DIV changes land on the next bit.
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_busy    = (r_state != StIdle);
  assign w_bit_end = (r_cnt == 16'd0);
  assign w_start   = r_en & ~w_empty & ((r_state == StIdle) | ((r_state == StStop) & w_bit_end));
  assign w_pop     = w_start;

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_line_nxt  = r_line;
    if (w_bit_end || (r_state == StIdle)) w_cnt_nxt = w_div_eff - 16'd1;
    else                                  w_cnt_nxt = r_cnt - 16'd1;
    unique case (r_state)
      StIdle: begin
        w_line_nxt = 1'b1;
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_nxt = StData;
          w_bit_nxt   = 3'd0;
          w_line_nxt  = r_shift[0];
        end
      end
      StData: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = StStop;
            w_line_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (w_pe) begin
              w_state_nxt = StParity;
              w_line_nxt  = r_par;
            end
`endif
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_line_nxt  = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (w_bit_end) begin
          w_state_nxt = StStop;
          w_line_nxt  = 1'b1;
        end
      end
`endif
      StStop: begin
        if (w_bit_end) begin
          w_state_nxt = StIdle;
          w_line_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_line_nxt  = 1'b1;
      end
    endcase
    // Pop the head and drive the start bit from the next cycle.
    if (w_start) begin
      w_state_nxt = StStart;
      w_shift_nxt = w_head;
      w_line_nxt  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_line  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_line  <= w_line_nxt;
    end
  end

  // Disabling only releases the pad; an in-flight frame still runs to completion.
  always_comb begin
    io_out         = '0;
    io_out[TX_PIN] = r_line;
    io_oeb         = '1;
    io_oeb[TX_PIN] = ~r_en;
    irq            = {2'b00, r_en & r_irq_en & w_empty & ~w_busy};
  end

endmodule

// File: tb/tb_user_proj_uart_tx.sv
// Testbench for user_proj_uart_tx: directed scenarios with literal expectations plus a
// randomized Wishbone stream checked every cycle against a frame-level behavioural model.

`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module tb_user_proj_uart_tx;

  localparam int FIFO_DEPTH = 8;
  localparam int TX_PIN     = 6;
  localparam logic [15:0] DIV_RESET = 16'd434;

  logic                     wb_clk_i, wb_rst_i;
  logic                     wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]               wbs_sel_i;
  logic [31:0]              wbs_adr_i, wbs_dat_i;
  logic                     wbs_ack_o;
  logic [31:0]              wbs_dat_o;
  logic [`MPRJ_IO_PADS-1:0] io_out, io_oeb;
  logic [2:0]               irq;

  int checks = 0;
  int failures = 0;

  user_proj_uart_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TX_PIN    (TX_PIN),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq      (irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is a list of line levels, one per bit; m_k counts cycles since the line fell.
  logic [7:0]  m_q[$];
  logic        m_en, m_irq_en, m_pe, m_ovf, m_act, m_ack, m_valid;
  logic [15:0] m_div;
  logic [31:0] m_rdata;
  logic [10:0] m_bits;
  int          m_k, m_total, m_bdiv;

  initial m_valid = 1'b0;

  task automatic model_step();
    logic acc, dec, pre_full;
    logic [1:0] off;
    logic [31:0] rd;
    logic [7:0] b;
    int nbits;
    if (wb_rst_i) begin
      m_q.delete();
      m_en = 0; m_irq_en = 0; m_pe = 0; m_ovf = 0; m_act = 0; m_ack = 0;
      m_rdata = '0; m_div = DIV_RESET; m_k = 0; m_bdiv = 1; m_total = 10; m_bits = '1;
      m_valid = 1;
      return;
    end
    acc = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == 24'h300000) && !m_ack;
    off = wbs_adr_i[3:2];
    pre_full = (m_q.size() == FIFO_DEPTH);
    dec = m_en && (m_q.size() != 0) && (!m_act || (m_k == m_total - 1));
    rd = '0;
    if (acc && !wbs_we_i) begin
      case (off)
        2'd1: rd = {17'd0, 7'(m_q.size()), 4'd0, m_ovf, (m_q.size() == 0), pre_full, m_act};
        2'd2: rd = {16'd0, m_div};
        2'd3: rd = {29'd0, m_pe, m_irq_en, m_en};
        default: rd = '0;
      endcase
    end
    m_ack = acc;
    m_rdata = rd;
    if (m_act) begin
      if (m_k == m_total - 1) m_act = 0;
      else m_k++;
    end
    if (dec) begin
      b = m_q.pop_front();
      m_bdiv = (m_div == 0) ? 1 : int'(m_div);
      if (m_pe) begin m_bits = {1'b1, ^b, b, 1'b0}; nbits = 11; end
      else begin m_bits = {2'b11, b, 1'b0}; nbits = 10; end
      m_total = nbits * m_bdiv;
      m_k = 0;
      m_act = 1;
    end
    if (acc && wbs_we_i) begin
      case (off)
        2'd0: if (wbs_sel_i[0]) begin
          if (pre_full && !dec) m_ovf = 1;
          else m_q.push_back(wbs_dat_i[7:0]);
        end
        2'd1: if (wbs_sel_i[0] && wbs_dat_i[3]) m_ovf = 0;
        2'd2: begin
          if (wbs_sel_i[0]) m_div[7:0] = wbs_dat_i[7:0];
          if (wbs_sel_i[1]) m_div[15:8] = wbs_dat_i[15:8];
        end
        default: if (wbs_sel_i[0]) begin
          m_en = wbs_dat_i[0];
          m_irq_en = wbs_dat_i[1];
`ifdef UART_TX_PARITY_EN
          m_pe = wbs_dat_i[2];
`endif
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge wb_clk_i);
    model_step();
  end

  // Compare every cycle, away from the active edge.
  logic [`MPRJ_IO_PADS-1:0] e_out, e_oeb;
  initial forever begin
    @(negedge wb_clk_i);
    if (m_valid) begin
      e_out = '0;
      e_out[TX_PIN] = m_act ? m_bits[m_k / m_bdiv] : 1'b1;
      e_oeb = '1;
      e_oeb[TX_PIN] = !m_en;
      chk("model_io_out", 64'(io_out), 64'(e_out));
      chk("model_io_oeb", 64'(io_oeb), 64'(e_oeb));
      chk("model_irq", 64'(irq), 64'({2'b00, m_en & m_irq_en & (m_q.size() == 0) & !m_act}));
      chk("model_ack", 64'(wbs_ack_o), 64'(m_ack));
      chk("model_dat", 64'(wbs_dat_o), 64'(m_rdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wb_xfer(input logic we, input logic [1:0] off, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd);
    int n;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = {24'h300000, 4'($urandom_range(0, 15)), off, 2'b00};
    wbs_dat_i = d;
    n = 0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!wbs_ack_o && n < 8);
    chk("ack_arrives", 64'(wbs_ack_o), 64'd1);
    rd = wbs_dat_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic wrs(input logic [1:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] rd;
    wb_xfer(1'b1, off, d, sel, rd);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    wrs(off, d, 4'hF);
  endtask

  task automatic rdchk(input string name, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, off, 32'd0, 4'hF, rd);
    chk(name, 64'(rd), 64'(exp));
  endtask

  task automatic pulse_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 0;
  endtask

  // Wait for the start bit, sample one level per bit, and count cycles until irq rises.
  task automatic measure(input string nm, input int div, input int nb, input logic [31:0] exp_bits);
    int k;
    logic [31:0] s;
    k = 0;
    while (io_out[TX_PIN] && k < 50) begin
      @(negedge wb_clk_i);
      k++;
    end
    chk({nm, "_start_bit"}, 64'(io_out[TX_PIN]), 64'd0);
    s = '0;
    k = 0;
    while (!irq[0] && k < 1000) begin
      if ((k % div) == 0 && (k / div) < nb) s[k / div] = io_out[TX_PIN];
      @(negedge wb_clk_i);
      k++;
    end
    chk({nm, "_cycles"}, 64'(k), 64'(nb * div));
    chk({nm, "_bits"}, 64'(s), 64'(exp_bits));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 0;

    // Reset state
    chk("rst_line", 64'(io_out[TX_PIN]), 64'd1);
    chk("rst_oeb", 64'(io_oeb), 64'({`MPRJ_IO_PADS{1'b1}}));
    chk("rst_irq", 64'(irq), 64'd0);
    rdchk("rst_status", 2'd1, 32'h0000_0004);
    rdchk("rst_div", 2'd2, 32'd434);
    rdchk("rst_ctrl", 2'd3, 32'd0);
    rdchk("data_reads_zero", 2'd0, 32'd0);

    // Single frame of 0x55 at DIV=4: levels 0,1,0,1,0,1,0,1,0,1 over 40 cycles
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h55);
    wr(2'd3, 32'd3);
    measure("single", 4, 10, 32'h2AA);

    // Overflow: 9 pushes into 8 entries
    pulse_reset();
    for (int i = 0; i < 9; i++) wr(2'd0, 32'(i));
    rdchk("ovf_status", 2'd1, 32'h0000_080A);
    wr(2'd1, 32'h8);
    rdchk("ovf_cleared", 2'd1, 32'h0000_0802);

    // Back-to-back 0xA0, 0x0F at DIV=2: 40 cycles, no gap, irq after last stop bit
    pulse_reset();
    wr(2'd2, 32'd2);
    wr(2'd0, 32'hA0);
    wr(2'd0, 32'h0F);
    wr(2'd3, 32'd3);
    measure("b2b", 2, 20, 32'h0008_7B40);

    // Disable mid-frame with a second byte queued
    pulse_reset();
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h33);
    wr(2'd0, 32'h44);
    wr(2'd3, 32'd1);
    repeat (6) @(negedge wb_clk_i);
    wr(2'd3, 32'd0);
    chk("dis_oeb", 64'(io_oeb[TX_PIN]), 64'd1);
    repeat (40) @(negedge wb_clk_i);
    chk("dis_line_idle", 64'(io_out[TX_PIN]), 64'd1);
    rdchk("dis_status", 2'd1, 32'h0000_0100);

`ifdef UART_TX_PARITY_EN
    // 0x07 with even parity at DIV=3: parity bit 1, 33-cycle frame
    pulse_reset();
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h07);
    wr(2'd3, 32'd7);
    measure("parity", 3, 11, 32'h0000_060E);
`endif

    // Randomized stream, checked by the model every cycle
    pulse_reset();
    wr(2'd2, 32'd2);
    for (int i = 0; i < 500; i++) begin
      int r;
      logic [31:0] rd;
      logic bad;
      r = $urandom_range(0, 99);
      if (i == 250) begin
        // Reset in the middle of a frame
        wr(2'd3, 32'd1);
        wr(2'd0, $urandom);
        repeat (4) @(negedge wb_clk_i);
        pulse_reset();
        chk("midreset_line", 64'(io_out[TX_PIN]), 64'd1);
        rdchk("midreset_status", 2'd1, 32'h0000_0004);
        wr(2'd2, 32'd2);
      end else if (r < 45) begin
        wrs(2'd0, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      end else if (r < 60) begin
        wb_xfer(1'b0, 2'($urandom), 32'd0, 4'($urandom), rd);
      end else if (r < 70) begin
        wr(2'd3, {29'd0, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7)});
      end else if (r < 75) begin
        wr(2'd1, $urandom);
      end else if (r < 82) begin
        if (!m_en && !m_act) wr(2'd2, 32'($urandom_range(0, 3)));
        else wr(2'd3, 32'd1);
      end else if (r < 90) begin
        bad = 1'($urandom);
        @(negedge wb_clk_i);
        wbs_cyc_i = bad; wbs_stb_i = 1; wbs_we_i = 1'($urandom); wbs_sel_i = 4'hF;
        wbs_adr_i = {bad ? 24'h300001 + 24'($urandom_range(0, 5)) : 24'h300000, 8'($urandom)};
        wbs_dat_i = $urandom;
        repeat (2) @(negedge wb_clk_i);
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      end else begin
        repeat ($urandom_range(1, 30)) @(negedge wb_clk_i);
      end
    end
    wr(2'd3, 32'd1);
    repeat (400) @(negedge wb_clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
